// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multicycle MIPS main control:
//   - instruction opcodes (IR[31:26])
//   - FSM state encoding (exposed on state_o for debug)
//   - datapath select codes for alu_op, alu_src_b and pc_source
//   - ctrl_word_t: the bundle of datapath strobes produced per state
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ALU operation requested from the ALU control decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // FSM states; codes 13..15 are unused
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BEQ       = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    // Datapath strobes generated from the current state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational output decode for the main control FSM.
// Ports:
//   state    in  current FSM state
//   mem_rdy  in  memory handshake; only consulted in FETCH and MEM_WR
//   cw       out control word (all strobes), zero in RESET and unused codes
// ---------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_rdy,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRC_B_FOUR;
                cw.alu_op    = ALU_OP_ADD;
                // IR and PC only capture once the instruction word is valid
                cw.ir_write  = mem_rdy;
                cw.pc_write  = mem_rdy;
            end
            S_DECODE: begin
                // Branch target computed speculatively while the opcode is decoded
                cw.alu_src_b = SRC_B_IMM_SH2;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                cw.mem_write  = 1'b1;
                cw.i_or_d     = 1'b1;
                // The store finishes in the cycle memory accepts it
                cw.instr_done = mem_rdy;
            end
            S_R_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_RT;
                cw.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                cw.reg_write  = 1'b1;
                cw.reg_dst    = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_BEQ: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRC_B_RT;
                cw.alu_op        = ALU_OP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PC_SRC_ALUOUT;
                cw.instr_done    = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_source  = PC_SRC_JUMP;
                cw.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// ---------------------------------------------------------------------------
// mc_main_control
// Multicycle MIPS main control FSM. Holds the state register and next-state
// logic; output strobes come from mc_ctrl_decode.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   opcode             IR[31:26], stable from DECODE to end of instruction
//   mem_rdy            memory completes the current access this cycle
//   pc_write .. alu_op datapath control strobes
//   instr_done         pulse in the final cycle of each legal instruction
//   illegal_op         pulse in DECODE for an unrecognised opcode
//   state_o            current state (debug)
// ---------------------------------------------------------------------------
module mc_main_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_rdy,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_word_t cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        illegal_op = 1'b0;
        case (state_reg)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_rdy) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_R:         state_next = S_R_EXEC;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default: begin
                        state_next = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                // Opcode is held by the IR, so only LW/SW can reach here;
                // anything else falls back to FETCH defensively.
                if (opcode == OP_LW) begin
                    state_next = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEM_WR;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM_RD:    if (mem_rdy) state_next = S_MEM_WB;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WR:    if (mem_rdy) state_next = S_FETCH;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_BEQ:       state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state   (state_reg),
        .mem_rdy (mem_rdy),
        .cw      (cw)
    );

    assign pc_write      = cw.pc_write;
    assign pc_write_cond = cw.pc_write_cond;
    assign pc_source     = cw.pc_source;
    assign i_or_d        = cw.i_or_d;
    assign mem_read      = cw.mem_read;
    assign mem_write     = cw.mem_write;
    assign ir_write      = cw.ir_write;
    assign mem_to_reg    = cw.mem_to_reg;
    assign reg_dst       = cw.reg_dst;
    assign reg_write     = cw.reg_write;
    assign alu_src_a     = cw.alu_src_a;
    assign alu_src_b     = cw.alu_src_b;
    assign alu_op        = cw.alu_op;
    assign instr_done    = cw.instr_done;
    assign state_o       = state_reg;

endmodule
